// File: rtl/lii_out_arbiter_pkg.sv
// =============================================================================
// lii_out_arbiter_pkg: shared FSM state, LII id width and sizing helper.
// Revision: 1.0
// =============================================================================
`default_nettype none

package lii_out_arbiter_pkg;

   localparam int LII_ID_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   // Never returns 0 so that index and counter vectors stay at least 1 bit wide.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lii_out_arbiter_rr_pick.sv
// =============================================================================
// lii_out_arbiter_rr_pick: combinational round-robin pick, first request at or after ptr.
// Revision: 1.0
// =============================================================================
`default_nettype none

module lii_out_arbiter_rr_pick
   import lii_out_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!gnt_valid && req[cand]) begin
            gnt_valid    = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/lii_out_arbiter.sv
// =============================================================================
// lii_out_arbiter: round-robin mux of N packed streams onto one registered LII out channel.
// Revision: 1.0
// =============================================================================
`default_nettype none

module lii_out_arbiter
   import lii_out_arbiter_pkg::*;
#(
   parameter int                  N      = 4,
   parameter int                  PW     = 64,
   parameter int                  BURST  = 8,
   parameter logic [LII_ID_W-1:0] SRC_ID = 8'h00,
   localparam int                 IW     = clog2_min1(N),
   localparam int                 CW     = clog2_min1(BURST)
) (
   input  logic                  aclk,
   input  logic                  arstn,
   input  logic [N*PW-1:0]       s_tdata,
   input  logic [N-1:0]          s_tvalid,
   input  logic [N-1:0]          s_tlast,
   input  logic [N*LII_ID_W-1:0] s_dst,
   output logic [N-1:0]          s_tready,
   output logic [PW-1:0]         lii_out_tdata,
   output logic                  lii_out_tvalid,
   input  logic                  lii_out_tready,
   output logic [LII_ID_W-1:0]   lii_out_src,
   output logic [LII_ID_W-1:0]   lii_out_dst,
   output logic                  ce,
   output logic [IW-1:0]         grant_id
);

   arb_state_t          state_q, state_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]       grant_id_q, grant_id_d;
   logic [N-1:0]        grant_oh_q, grant_oh_d;
   logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic [PW-1:0]       out_data_q, out_data_d;
   logic [LII_ID_W-1:0] out_dst_q, out_dst_d;

   logic [PW-1:0]       s_data_arr [N];
   logic [LII_ID_W-1:0] s_dst_arr  [N];
   logic [N-1:0]        pick_oh;
   logic [IW-1:0]       pick_idx;
   logic                pick_valid;
   logic                buf_free;
   logic                sel_valid;
   logic                sel_last;
   logic                accept;
   logic                burst_done;
   logic [IW-1:0]       ptr_after;

   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign s_data_arr[gi] = s_tdata[gi*PW +: PW];
      assign s_dst_arr[gi]  = s_dst[gi*LII_ID_W +: LII_ID_W];
   end

   lii_out_arbiter_rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_rr_pick (
      .req       (s_tvalid),
      .ptr       (rr_ptr_q),
      .gnt_oh    (pick_oh),
      .gnt_idx   (pick_idx),
      .gnt_valid (pick_valid)
   );

   assign buf_free   = !out_valid_q || lii_out_tready;
   assign sel_valid  = s_tvalid[grant_id_q];
   assign sel_last   = s_tlast[grant_id_q];
   assign accept     = (state_q == ST_GRANT) && sel_valid && buf_free;
   assign burst_done = sel_last || (beat_cnt_q == CW'(BURST - 1));
   assign ptr_after  = (grant_id_q == IW'(N - 1)) ? '0 : grant_id_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      grant_oh_d  = grant_oh_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_dst_d   = out_dst_q;

      // Drain first; a same-cycle load below overrides it so tvalid stays high.
      if (out_valid_q && lii_out_tready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = s_data_arr[grant_id_q];
         out_dst_d   = s_dst_arr[grant_id_q];
         beat_cnt_d  = beat_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_GRANT;
               grant_id_d = pick_idx;
               grant_oh_d = pick_oh;
               beat_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            // Release on packet end, burst limit, or an idle requester with room to take a beat.
            if ((accept && burst_done) || (!sel_valid && buf_free)) begin
               state_d  = ST_IDLE;
               rr_ptr_d = ptr_after;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         grant_oh_q  <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dst_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         grant_oh_q  <= grant_oh_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dst_q   <= out_dst_d;
      end
   end

   assign s_tready       = (state_q == ST_GRANT) ? (grant_oh_q & {N{buf_free}}) : '0;
   assign lii_out_tdata  = out_data_q;
   assign lii_out_tvalid = out_valid_q;
   assign lii_out_src    = SRC_ID;
   assign lii_out_dst    = out_dst_q;
   assign ce             = !(out_valid_q && !lii_out_tready);
   assign grant_id       = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_lii_out_arbiter.sv
// =============================================================================
// tb_lii_out_arbiter: directed vector table plus multi-cycle sequences for lii_out_arbiter.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_lii_out_arbiter;

   localparam int N  = 4;
   localparam int PW = 16;

   logic            aclk = 1'b0;
   logic            arstn = 1'b0;
   logic [N*PW-1:0] s_tdata = '0;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tlast = '0;
   logic [N*8-1:0]  s_dst = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
   logic [N-1:0]    s_tready;
   logic [PW-1:0]   lii_out_tdata;
   logic            lii_out_tvalid;
   logic            lii_out_tready = 1'b1;
   logic [7:0]      lii_out_src;
   logic [7:0]      lii_out_dst;
   logic            ce;
   logic [1:0]      grant_id;

   lii_out_arbiter #(
      .N      (N),
      .PW     (PW),
      .BURST  (8),
      .SRC_ID (8'hA5)
   ) dut (
      .aclk           (aclk),
      .arstn          (arstn),
      .s_tdata        (s_tdata),
      .s_tvalid       (s_tvalid),
      .s_tlast        (s_tlast),
      .s_dst          (s_dst),
      .s_tready       (s_tready),
      .lii_out_tdata  (lii_out_tdata),
      .lii_out_tvalid (lii_out_tvalid),
      .lii_out_tready (lii_out_tready),
      .lii_out_src    (lii_out_src),
      .lii_out_dst    (lii_out_dst),
      .ce             (ce),
      .grant_id       (grant_id)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic        rdy;
      logic [15:0] dbase;
      logic        rst_before;
      logic [3:0]  e_srdy;
      logic        e_ov;
      logic [15:0] e_od;
      logic [7:0]  e_dst;
      logic [1:0]  e_gid;
      logic        e_ce;
   } vec_t;

   vec_t       vt [17];
   logic [23:0] outq [$];
   int         hist [17];
   int         n_total = 0;
   int         n_pass  = 0;
   int         nh;
   int         k;
   logic       s0_done;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic do_reset();
      arstn          = 1'b0;
      s_tvalid       = '0;
      s_tlast        = '0;
      s_tdata        = '0;
      lii_out_tready = 1'b1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      arstn = 1'b1;
   endtask

   task automatic drive_streams(input logic [3:0] vld, input logic [3:0] lst, input logic [15:0] base);
      s_tvalid = vld;
      s_tlast  = lst;
      for (int i = 0; i < N; i++) s_tdata[i*PW +: PW] = base + 16'(i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Single stream, 3-beat packet, then all streams with 1-beat packets after a reset.
      vt[0]  = '{4'b0100, 4'b0000, 1'b1, 16'h0100, 1'b0, 4'b0000, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b1};
      vt[1]  = '{4'b0100, 4'b0000, 1'b1, 16'h0100, 1'b0, 4'b0100, 1'b0, 16'h0000, 8'h00, 2'd2, 1'b1};
      vt[2]  = '{4'b0100, 4'b0000, 1'b1, 16'h0110, 1'b0, 4'b0100, 1'b1, 16'h0102, 8'hD2, 2'd2, 1'b1};
      vt[3]  = '{4'b0100, 4'b0100, 1'b1, 16'h0120, 1'b0, 4'b0100, 1'b1, 16'h0112, 8'hD2, 2'd2, 1'b1};
      vt[4]  = '{4'b0000, 4'b0000, 1'b1, 16'h0130, 1'b0, 4'b0000, 1'b1, 16'h0122, 8'hD2, 2'd2, 1'b1};
      vt[5]  = '{4'b0000, 4'b0000, 1'b1, 16'h0140, 1'b0, 4'b0000, 1'b0, 16'h0122, 8'hD2, 2'd2, 1'b1};
      vt[6]  = '{4'b1111, 4'b1111, 1'b1, 16'h0200, 1'b1, 4'b0000, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b1};
      vt[7]  = '{4'b1111, 4'b1111, 1'b1, 16'h0210, 1'b0, 4'b0001, 1'b0, 16'h0000, 8'h00, 2'd0, 1'b1};
      vt[8]  = '{4'b1111, 4'b1111, 1'b1, 16'h0220, 1'b0, 4'b0000, 1'b1, 16'h0210, 8'hD0, 2'd0, 1'b1};
      vt[9]  = '{4'b1111, 4'b1111, 1'b1, 16'h0230, 1'b0, 4'b0010, 1'b0, 16'h0210, 8'hD0, 2'd1, 1'b1};
      vt[10] = '{4'b1111, 4'b1111, 1'b1, 16'h0240, 1'b0, 4'b0000, 1'b1, 16'h0231, 8'hD1, 2'd1, 1'b1};
      vt[11] = '{4'b1111, 4'b1111, 1'b1, 16'h0250, 1'b0, 4'b0100, 1'b0, 16'h0231, 8'hD1, 2'd2, 1'b1};
      vt[12] = '{4'b1111, 4'b1111, 1'b1, 16'h0260, 1'b0, 4'b0000, 1'b1, 16'h0252, 8'hD2, 2'd2, 1'b1};
      vt[13] = '{4'b1111, 4'b1111, 1'b1, 16'h0270, 1'b0, 4'b1000, 1'b0, 16'h0252, 8'hD2, 2'd3, 1'b1};
      vt[14] = '{4'b1111, 4'b1111, 1'b1, 16'h0280, 1'b0, 4'b0000, 1'b1, 16'h0273, 8'hD3, 2'd3, 1'b1};
      vt[15] = '{4'b1111, 4'b1111, 1'b1, 16'h0290, 1'b0, 4'b0001, 1'b0, 16'h0273, 8'hD3, 2'd0, 1'b1};
      vt[16] = '{4'b0000, 4'b0000, 1'b1, 16'h02A0, 1'b0, 4'b0000, 1'b1, 16'h0290, 8'hD0, 2'd0, 1'b1};

      do_reset();
      #1;
      chk("reset.tvalid", 32'(lii_out_tvalid), 32'd0);
      chk("reset.tdata", 32'(lii_out_tdata), 32'd0);
      chk("reset.dst", 32'(lii_out_dst), 32'd0);
      chk("reset.src", 32'(lii_out_src), 32'hA5);
      chk("reset.s_tready", 32'(s_tready), 32'd0);
      chk("reset.ce", 32'(ce), 32'd1);
      chk("reset.grant_id", 32'(grant_id), 32'd0);

      for (int r = 0; r < 17; r++) begin
         if (vt[r].rst_before) do_reset();
         @(negedge aclk);
         drive_streams(vt[r].vld, vt[r].lst, vt[r].dbase);
         lii_out_tready = vt[r].rdy;
         #1;
         chk($sformatf("row%0d.s_tready", r), 32'(s_tready), 32'(vt[r].e_srdy));
         chk($sformatf("row%0d.tvalid", r), 32'(lii_out_tvalid), 32'(vt[r].e_ov));
         chk($sformatf("row%0d.tdata", r), 32'(lii_out_tdata), 32'(vt[r].e_od));
         chk($sformatf("row%0d.dst", r), 32'(lii_out_dst), 32'(vt[r].e_dst));
         chk($sformatf("row%0d.grant_id", r), 32'(grant_id), 32'(vt[r].e_gid));
         chk($sformatf("row%0d.ce", r), 32'(ce), 32'(vt[r].e_ce));
      end

      // Burst limit: streams 1 and 3 never assert tlast.
      do_reset();
      drive_streams(4'b1010, 4'b0000, 16'h0000);
      nh = 0;
      for (int cyc = 0; cyc < 100 && nh < 17; cyc++) begin
         @(negedge aclk);
         #1;
         if (|(s_tready & s_tvalid)) begin
            for (int i = 0; i < N; i++) if (s_tready[i]) hist[nh] = i;
            nh++;
         end
      end
      chk("burst.handshakes", 32'(nh), 32'd17);
      for (int j = 0; j < 17; j++)
         chk($sformatf("burst.stream[%0d]", j), 32'(hist[j]), (j < 8 || j == 16) ? 32'd1 : 32'd3);

      // Back-pressure: lii_out_tready low for cycles 4..8 of a 6-beat packet on stream 0.
      do_reset();
      outq.delete();
      k = 0;
      for (int cyc = 0; cyc < 17; cyc++) begin
         @(negedge aclk);
         lii_out_tready = !(cyc >= 4 && cyc < 9);
         s_tvalid       = (k < 6) ? 4'b0001 : 4'b0000;
         s_tlast        = (k == 5) ? 4'b0001 : 4'b0000;
         s_tdata[15:0]  = 16'h0300 + 16'(k);
         #1;
         if (lii_out_tvalid && lii_out_tready) outq.push_back({lii_out_dst, lii_out_tdata});
         if (cyc >= 4 && cyc < 9) begin
            chk($sformatf("stall%0d.tvalid", cyc), 32'(lii_out_tvalid), 32'd1);
            chk($sformatf("stall%0d.tdata", cyc), 32'(lii_out_tdata), 32'h0302);
            chk($sformatf("stall%0d.dst", cyc), 32'(lii_out_dst), 32'hD0);
            chk($sformatf("stall%0d.s_tready", cyc), 32'(s_tready), 32'd0);
            chk($sformatf("stall%0d.ce", cyc), 32'(ce), 32'd0);
         end
         if (s_tready[0] && s_tvalid[0]) k++;
      end
      chk("stall.beats", 32'(outq.size()), 32'd6);
      for (int j = 0; j < 6 && j < outq.size(); j++)
         chk($sformatf("stall.beat[%0d]", j), 32'(outq[j]), {8'h0, 8'hD0, 16'h0300 + 16'(j)});

      // Reset mid-burst: stream 2 sends 3 of 6 beats, then arstn pulses.
      lii_out_tready = 1'b1;
      k = 0;
      for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
         @(negedge aclk);
         s_tvalid           = 4'b0100;
         s_tlast            = (k == 5) ? 4'b0100 : 4'b0000;
         s_tdata[47:32]     = 16'h0400 + 16'(k);
         #1;
         if (s_tready[2] && s_tvalid[2]) k++;
      end
      chk("midrst.pre_beats", 32'(k), 32'd3);
      @(posedge aclk);
      #2;
      arstn = 1'b0;
      #1;
      chk("midrst.tvalid_async", 32'(lii_out_tvalid), 32'd0);
      chk("midrst.tdata", 32'(lii_out_tdata), 32'd0);
      chk("midrst.s_tready", 32'(s_tready), 32'd0);
      chk("midrst.ce", 32'(ce), 32'd1);
      @(posedge aclk);
      #1;
      chk("midrst.tvalid_edge", 32'(lii_out_tvalid), 32'd0);
      @(negedge aclk);
      arstn = 1'b1;

      outq.delete();
      s0_done = 1'b0;
      for (int cyc = 0; cyc < 40 && outq.size() < 4; cyc++) begin
         if (cyc > 0) @(negedge aclk);
         s_tvalid       = {1'b0, (k < 6), 1'b0, !s0_done};
         s_tlast        = {1'b0, (k == 5), 1'b0, 1'b1};
         s_tdata[15:0]  = 16'h04F0;
         s_tdata[47:32] = 16'h0400 + 16'(k);
         #1;
         if (cyc < 2) chk($sformatf("postrst%0d.tvalid", cyc), 32'(lii_out_tvalid), 32'd0);
         if (cyc == 1) chk("postrst.first_grant", 32'(s_tready), 32'b0001);
         if (lii_out_tvalid && lii_out_tready) outq.push_back({lii_out_dst, lii_out_tdata});
         if (s_tready[0] && s_tvalid[0]) s0_done = 1'b1;
         if (s_tready[2] && s_tvalid[2]) k++;
      end
      chk("postrst.beats", 32'(outq.size()), 32'd4);
      if (outq.size() >= 4) begin
         chk("postrst.beat0", 32'(outq[0]), 32'hD0_04F0);
         chk("postrst.beat1", 32'(outq[1]), 32'hD2_0403);
         chk("postrst.beat2", 32'(outq[2]), 32'hD2_0404);
         chk("postrst.beat3", 32'(outq[3]), 32'hD2_0405);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
